// File: rtl/bitrev_reorder_ctrl.sv
// ---------------------------------------------------------------------------
// bitrev_reorder_ctrl
//
// Ping-pong reorder buffer for the R2SDF FFT output. Each frame of 2^N
// samples is written in arrival (natural) order into one of two banks. It is
// then read back in bit-reversed index order, so the downstream consumer sees
// natural-order bins. One bank fills while the other drains, which sustains
// one sample per cycle on both sides with no bubble at frame boundaries.
//
// Parameters
//   N   log2 of frame length (frame = 2^N samples), N >= 1
//   DW  sample width in bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data valid
//   in_ready   write bank is empty; sample can be taken this cycle
//   in_data    sample, natural order within frame
//   out_valid  read bank holds a complete frame
//   out_ready  downstream accepts out_data
//   out_data   sample, bit-reversed order within frame
//   out_last   final sample of the output frame
//   busy       any bank full or a partial frame is being written
//
// Optional build macro BITREV_FRAME_CNT_EN adds:
//   frame_cnt  [15:0] completed output frames (wraps)
//   ovf_flag   sticky: in_valid seen while in_ready was low
// ---------------------------------------------------------------------------

// One frame bank: synchronous write, combinational read. The contents are
// deliberately not reset; the full flags in the controller decide validity.
module bitrev_bank #(
    parameter int N  = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [N-1:0]  waddr,
    input  logic [DW-1:0] wdata,
    input  logic [N-1:0]  raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module bitrev_reorder_ctrl #(
    parameter int N  = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
`ifdef BITREV_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt,
    output logic          ovf_flag
`else
`endif
);
    localparam logic [N-1:0] LAST = {N{1'b1}};

    logic [1:0]          full;
    logic                wr_bank;
    logic                rd_bank;
    logic [N-1:0]        wr_cnt;
    logic [N-1:0]        rd_cnt;
    logic [N-1:0]        rd_addr;
    logic [1:0][DW-1:0]  bank_rd;

    logic wr_fire, rd_fire, wr_done, rd_done;

    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_last  = out_valid & (rd_cnt == LAST);
    assign out_data  = bank_rd[rd_bank];
    assign busy      = (|full) | (wr_cnt != '0);

    assign wr_fire = in_valid & in_ready;
    assign rd_fire = out_valid & out_ready;
    assign wr_done = wr_fire & (wr_cnt == LAST);
    assign rd_done = rd_fire & (rd_cnt == LAST);

    // Read address is the read counter with its bits mirrored.
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < N; i++) rd_addr[i] = rd_cnt[N-1-i];
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bitrev_bank #(.N(N), .DW(DW)) u_bank (
            .clk   (clk),
            .we    (wr_fire & (wr_bank == 1'(b))),
            .waddr (wr_cnt),
            .wdata (in_data),
            .raddr (rd_addr),
            .rdata (bank_rd[b])
        );
    end

    // Counters wrap naturally at 2^N. A bank is only set while empty (write
    // side gated by in_ready) and only cleared while full (read side gated by
    // out_valid), so a same-cycle set and clear always land on different banks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_done) rd_bank <= ~rd_bank;
            end
            for (int b = 0; b < 2; b++) begin
                if (wr_done && (wr_bank == 1'(b)))      full[b] <= 1'b1;
                else if (rd_done && (rd_bank == 1'(b))) full[b] <= 1'b0;
            end
        end
    end

`ifdef BITREV_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            if (rd_done)              frame_cnt <= frame_cnt + 16'd1;
            if (in_valid & ~in_ready) ovf_flag  <= 1'b1;
        end
    end
`else
    // Frame statistics not built.
`endif
endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
module tb_bitrev_reorder_ctrl;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int F  = 1 << N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
`ifdef BITREV_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
    logic          ovf_flag;
`endif

    always #5 clk = ~clk;

    bitrev_reorder_ctrl #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef BITREV_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt),
        .ovf_flag  (ovf_flag)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] part[$];
    int vectors     = 0;
    int miscompares = 0;
    int frames_out  = 0;
    int rdy_mode    = 0;
    int rdy_ph      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < N; i++)
            if (((k >> i) & 1) != 0) r |= 1 << (N - 1 - i);
        return r;
    endfunction

    // Reference model: gather a whole frame, then queue it in bit-reversed order.
    task automatic model_accept(input logic [DW-1:0] v);
        part.push_back(v);
        if (part.size() == F) begin
            for (int k = 0; k < F; k++) expq.push_back('{d: part[rev(k)], l: (k == F - 1)});
            part.delete();
        end
    endtask

    task automatic push_sample(input logic [DW-1:0] v, input bit must_ready);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (must_ready) check("in_ready_b2b", in_ready, 1);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (acc) model_accept(v);
        else check("in_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (expq.size() != 0) check("drain_timeout", expq.size(), 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        @(posedge clk); #1;
    endtask

    // Downstream ready generator.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                2: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = (rdy_ph == 0);
                    rdy_ph    = (rdy_ph + 1) % 3;
                end
            endcase
        end
    end

    // Monitor: a popped entry corresponds to the handshake at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", out_valid, expq.size() > 0);
            if (out_valid && expq.size() > 0) begin
                check("out_data", out_data, expq[0].d);
                check("out_last", out_last, expq[0].l);
                if (out_ready) begin
                    if (expq[0].l) frames_out++;
                    void'(expq.pop_front());
                end
            end else begin
                check("out_last_idle", out_last, 0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen_last;
        bit rose;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
`ifdef BITREV_FRAME_CNT_EN
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_ovf", ovf_flag, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame, latency to first output.
        for (int v = 0; v < F; v++) push_sample(v, 1);
        @(negedge clk);
        check("first_valid", out_valid, 1);
        check("first_data", out_data, 0);
        @(posedge clk); #1;
        drain();

        // Three back-to-back frames; input never throttled.
        for (int v = 0; v < 3 * F; v++) push_sample(v, 1);
        drain();

        // Both banks fill, input held off, then released.
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int v = 0; v < 2 * F; v++) push_sample(v, 0);
        in_valid = 1'b1;
        in_data  = 2 * F;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        rdy_mode  = 0;
        seen_last = 1'b0;
        rose      = 1'b0;
        for (int t = 0; t < 40 && !rose; t++) begin
            @(negedge clk);
            check("release_in_ready", in_ready, seen_last);
            rose = in_ready;
            if (out_valid && out_ready && out_last) seen_last = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (rose) model_accept(2 * F);
        else check("release_timeout", 0, 1);
        for (int v = 2 * F + 1; v < 3 * F; v++) push_sample(v, 0);
        drain();
`ifdef BITREV_FRAME_CNT_EN
        check("ovf_set", ovf_flag, 1);
        check("frame_cnt_a", frame_cnt, frames_out);
`endif

        // Reset mid-frame discards the partial frame.
        for (int v = 0; v < 5; v++) push_sample(200 + v, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        part.delete();
        expq.delete();
        frames_out = 0;
        @(negedge clk);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
`ifdef BITREV_FRAME_CNT_EN
        check("mrst_ovf", ovf_flag, 0);
`endif
        @(posedge clk); #1;
        for (int v = 0; v < F; v++) push_sample(100 + v, 1);
        drain();

        // Stall pattern 1,0,0 while draining, random data.
        rdy_mode = 3;
        for (int v = 0; v < 3 * F; v++) push_sample($urandom, 0);
        drain();

        // Random input gaps and random downstream ready.
        rdy_mode = 2;
        for (int v = 0; v < 6 * F; v++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            push_sample($urandom, 0);
        end
        drain();
`ifdef BITREV_FRAME_CNT_EN
        check("frame_cnt_b", frame_cnt, frames_out);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
